// File: rtl/pulse_trigger_capture_if.sv
// pulse_trigger_capture_if: phase sample stream in, event record stream out
interface pulse_trigger_capture_if #(
  parameter int CH_W = 8,
  parameter int DATA_W = 16,
  parameter int TS_W = 32
);
  logic              in_valid;
  logic [CH_W-1:0]   in_ch;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [CH_W-1:0]   out_ch;
  logic [DATA_W-1:0] out_data;
  logic [TS_W-1:0]   out_ts;
  modport master (
    output in_valid, in_ch, in_data, out_ready,
    input  out_valid, out_ch, out_data, out_ts
  );
  modport slave (
    input  in_valid, in_ch, in_data, out_ready,
    output out_valid, out_ch, out_data, out_ts
  );
endinterface

// File: rtl/pulse_trigger_capture.sv
// pulse_trigger_capture: per-channel threshold trigger with deadtime and FWFT event FIFO; define PULSE_TRIG_DROP_CNT_EN to implement drop_count
module pulse_trigger_capture #(
  parameter int CH_W = 8,
  parameter int DATA_W = 16,
  parameter int TS_W = 32,
  parameter int FIFO_AW = 4
) (
  input  logic        user_clk,
  input  logic        user_rst_n,
  input  logic [31:0] thresh_reg,
  output logic        init_done,
  output logic [15:0] drop_count,
  pulse_trigger_capture_if.slave bus
);
  localparam logic [0:0] S_INIT = 1'b0;
  localparam logic [0:0] S_RUN = 1'b1;
  localparam int EW = CH_W + DATA_W + TS_W;
  typedef struct packed {
    logic              valid;
    logic [CH_W-1:0]   ch;
    logic [DATA_W-1:0] data;
    logic [TS_W-1:0]   ts;
    logic              en;
    logic [11:0]       dt;
    logic [15:0]       t;
  } smp_t;
  logic [0:0] state_q, state_d;
  logic [CH_W-1:0] sweep_q, sweep_d, mem_addr;
  logic [TS_W-1:0] ts_q, ts_d;
  smp_t s0_q, s0_d, s1_q, s1_d;
  logic [11:0] cnt_q, cnt_d, wr_cnt;
  logic [11:0] cnt_mem [2**CH_W];
  logic [EW-1:0] fifo_mem [2**FIFO_AW];
  logic [FIFO_AW:0] wr_q, wr_d, rd_q, rd_d, level;
  logic [DATA_W:0] neg_t;
  logic run, fire, full, push, pop, mem_we;
  logic unused;
  assign unused = ^thresh_reg[30:28];
  always_comb begin
    run = state_q == S_RUN;
    state_d = (!run && &sweep_q) ? S_RUN : state_q;
    sweep_d = run ? sweep_q : sweep_q + CH_W'(1);
    ts_d = run ? ts_q + TS_W'(1) : ts_q;
    s0_d = {bus.in_valid & run, bus.in_ch, bus.in_data, ts_q, thresh_reg[31], thresh_reg[27:0]};
    s1_d = s0_q;
    neg_t = '0 - (DATA_W+1)'(s1_q.t);
    fire = s1_q.valid && s1_q.en && cnt_q == 12'd0 &&
           $signed({s1_q.data[DATA_W-1], s1_q.data}) <= $signed(neg_t);
    wr_cnt = fire ? s1_q.dt : (s1_q.en && cnt_q != 12'd0) ? cnt_q - 12'd1 : 12'd0;
    // same-channel sample one cycle behind sees the counter being written now
    cnt_d = (s1_q.valid && s1_q.ch == s0_q.ch) ? wr_cnt : cnt_mem[s0_q.ch];
    mem_we = !run || s1_q.valid;
    mem_addr = run ? s1_q.ch : sweep_q;
    level = wr_q - rd_q;
    full = level[FIFO_AW];
    bus.out_valid = level != '0;
    pop = bus.out_valid && bus.out_ready;
    push = fire && (!full || pop);
    wr_d = wr_q + (FIFO_AW+1)'(push);
    rd_d = rd_q + (FIFO_AW+1)'(pop);
    {bus.out_ch, bus.out_data, bus.out_ts} = bus.out_valid ? fifo_mem[rd_q[FIFO_AW-1:0]] : '0;
    init_done = run;
  end
  always_ff @(posedge user_clk) begin
    if (!user_rst_n) begin
      state_q <= S_INIT;
      sweep_q <= '0;
      ts_q <= '0;
      s0_q <= '0;
      s1_q <= '0;
      cnt_q <= '0;
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
      ts_q <= ts_d;
      s0_q <= s0_d;
      s1_q <= s1_d;
      cnt_q <= cnt_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end
  always_ff @(posedge user_clk) begin
    if (mem_we) cnt_mem[mem_addr] <= run ? wr_cnt : 12'd0;
    if (push) fifo_mem[wr_q[FIFO_AW-1:0]] <= {s1_q.ch, s1_q.data, s1_q.ts};
  end
`ifdef PULSE_TRIG_DROP_CNT_EN
  logic [15:0] drop_count_q, drop_count_d;
  always_comb drop_count_d = (fire && !push && drop_count_q != 16'hFFFF) ? drop_count_q + 16'd1 : drop_count_q;
  always_ff @(posedge user_clk) drop_count_q <= !user_rst_n ? 16'd0 : drop_count_d;
  assign drop_count = drop_count_q;
`else
  assign drop_count = 16'd0;
`endif
endmodule

// File: tb/tb_pulse_trigger_capture.sv
// tb_pulse_trigger_capture: randomized bench against a sample-by-sample reference model
module tb_pulse_trigger_capture;
`ifdef PULSE_TRIG_DROP_CNT_EN
  localparam bit DROP_EN = 1'b1;
`else
  localparam bit DROP_EN = 1'b0;
`endif
  logic user_clk = 1'b0;
  logic user_rst_n = 1'b0;
  logic [31:0] thresh_reg = '0;
  logic init_done;
  logic [15:0] drop_count;
  pulse_trigger_capture_if #(.CH_W(8), .DATA_W(16), .TS_W(32)) bus();
  pulse_trigger_capture #(.CH_W(8), .DATA_W(16), .TS_W(32), .FIFO_AW(4)) dut (
    .user_clk(user_clk),
    .user_rst_n(user_rst_n),
    .thresh_reg(thresh_reg),
    .init_done(init_done),
    .drop_count(drop_count),
    .bus(bus)
  );
  always #5 user_clk = ~user_clk;
  int cyc = 0;
  int run0 = 0;
  int total = 0;
  int bad = 0;
  int drops = 0;
  int dt_m [256];
  logic [55:0] exp_q [$];
  always @(posedge user_clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge user_clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic set_thr(input int t, input int d, input bit en);
    thresh_reg = {en, 3'b000, 12'(d), 16'(t)};
  endtask

  // model: each sample is judged in arrival order against its channel's remaining deadtime
  task automatic send(input int ch, input int data);
    int t;
    int d;
    t = int'(thresh_reg[15:0]);
    d = int'(thresh_reg[27:16]);
    bus.in_valid = 1'b1;
    bus.in_ch = 8'(ch);
    bus.in_data = 16'(data);
    if (!thresh_reg[31]) dt_m[ch] = 0;
    else if (dt_m[ch] == 0 && data <= -t) begin
      dt_m[ch] = d;
      if (exp_q.size() >= 16) drops++;
      else exp_q.push_back({8'(ch), 16'(data), 32'(cyc - run0)});
    end else if (dt_m[ch] > 0) dt_m[ch]--;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic assert_rst();
    user_rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    idle(3);
  endtask

  task automatic release_rst();
    user_rst_n = 1'b1;
    run0 = cyc + 256;
    exp_q.delete();
    drops = 0;
    foreach (dt_m[i]) dt_m[i] = 0;
  endtask

  task automatic test_reset();
    assert_rst();
    @(negedge user_clk);
    total++;
    if ({init_done, bus.out_valid, bus.out_ch, bus.out_data, bus.out_ts, drop_count} !== '0) begin
      bad++;
      $display("FAIL reset_state: init=%b v=%b ch=%h d=%h ts=%h drop=%0d want all 0",
               init_done, bus.out_valid, bus.out_ch, bus.out_data, bus.out_ts, drop_count);
    end
    tick();
    set_thr(0, 0, 1'b1);
    release_rst();
    for (int i = 1; i <= 256; i++) begin
      bus.in_valid = i >= 250;
      bus.in_ch = 8'(i);
      bus.in_data = -16'sd1000;
      @(negedge user_clk);
      total++;
      if (init_done !== 1'b0) begin
        bad++;
        $display("FAIL init_low: cycle %0d init_done=%b want 0", i, init_done);
      end
      tick();
    end
    bus.in_valid = 1'b0;
    @(negedge user_clk);
    total++;
    if (init_done !== 1'b1) begin
      bad++;
      $display("FAIL init_rise: cycle 257 init_done=%b want 1", init_done);
    end
    idle(5);
    @(negedge user_clk);
    total++;
    if (bus.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL init_ignore: out_valid=%b want 0", bus.out_valid);
    end
    tick();
  endtask

  task automatic test_single();
    int n;
    set_thr(100, 0, 1'b1);
    send(5, -100);
    for (int k = 1; k <= 3; k++) begin
      @(negedge user_clk);
      total++;
      if (bus.out_valid !== (k == 3)) begin
        bad++;
        $display("FAIL latency: N+%0d out_valid=%b want %b", k, bus.out_valid, k == 3);
      end
      if (k < 3) tick();
    end
    tick();
    send(5, -99);
    set_thr(32768, 0, 1'b1);
    send(3, -32768);
    send(3, -32767);
    set_thr(65535, 0, 1'b1);
    send(4, -32768);
    idle(4);
    n = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge user_clk);
      if (!bus.out_valid) break;
      total++;
      n++;
      if (exp_q.size() == 0 || {bus.out_ch, bus.out_data, bus.out_ts} !== exp_q[0]) begin
        bad++;
        $display("FAIL single_event: got %h want %h", {bus.out_ch, bus.out_data, bus.out_ts},
                 exp_q.size() ? exp_q[0] : 56'h0);
      end
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
    end
    total++;
    if (n !== 2) begin
      bad++;
      $display("FAIL single_count: got %0d events want 2", n);
    end
    tick();
  endtask

  task automatic test_deadtime(input int ch, input int gap);
    int n;
    set_thr(100, 3, 1'b1);
    for (int i = 0; i < 6; i++) begin
      send(ch, -200);
      idle(gap);
    end
    idle(4);
    n = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge user_clk);
      if (!bus.out_valid) break;
      total++;
      n++;
      if (exp_q.size() == 0 || {bus.out_ch, bus.out_data, bus.out_ts} !== exp_q[0]) begin
        bad++;
        $display("FAIL deadtime_event gap=%0d: got %h want %h", gap,
                 {bus.out_ch, bus.out_data, bus.out_ts}, exp_q.size() ? exp_q[0] : 56'h0);
      end
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
    end
    total++;
    if (n !== 2) begin
      bad++;
      $display("FAIL deadtime_count gap=%0d: got %0d events want 2", gap, n);
    end
    tick();
  endtask

  task automatic test_fifo_full();
    int n;
    logic [55:0] head;
    set_thr(100, 0, 1'b1);
    for (int i = 0; i < 20; i++) send(20 + i, -150);
    idle(4);
    @(negedge user_clk);
    total++;
    if (drop_count !== 16'(DROP_EN ? drops : 0) || bus.out_valid !== 1'b1) begin
      bad++;
      $display("FAIL fifo_drops: drop=%0d v=%b want drop=%0d v=1", drop_count, bus.out_valid,
               DROP_EN ? drops : 0);
    end
    tick();
    head = exp_q.pop_front();
    send(50, -150);
    tick();
    bus.out_ready = 1'b1;
    @(negedge user_clk);
    total++;
    if (bus.out_valid !== 1'b1 || {bus.out_ch, bus.out_data, bus.out_ts} !== head) begin
      bad++;
      $display("FAIL full_pushpop_head: v=%b got %h want %h", bus.out_valid,
               {bus.out_ch, bus.out_data, bus.out_ts}, head);
    end
    tick();
    bus.out_ready = 1'b0;
    idle(2);
    @(negedge user_clk);
    total++;
    if (drop_count !== 16'(DROP_EN ? drops : 0)) begin
      bad++;
      $display("FAIL full_pushpop_drop: drop=%0d want %0d", drop_count, DROP_EN ? drops : 0);
    end
    tick();
    n = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge user_clk);
      if (!bus.out_valid) break;
      total++;
      n++;
      if (exp_q.size() == 0 || {bus.out_ch, bus.out_data, bus.out_ts} !== exp_q[0]) begin
        bad++;
        $display("FAIL fifo_order: got %h want %h", {bus.out_ch, bus.out_data, bus.out_ts},
                 exp_q.size() ? exp_q[0] : 56'h0);
      end
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
    end
    total++;
    if (n !== 16) begin
      bad++;
      $display("FAIL fifo_count: got %0d events want 16", n);
    end
    tick();
  endtask

  task automatic test_enable();
    int n;
    set_thr(100, 0, 1'b0);
    for (int i = 0; i < 3; i++) send(9, -200);
    set_thr(100, 5, 1'b1);
    send(10, -200);
    send(10, -200);
    set_thr(100, 5, 1'b0);
    send(10, -200);
    set_thr(100, 5, 1'b1);
    send(10, -200);
    idle(4);
    n = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge user_clk);
      if (!bus.out_valid) break;
      total++;
      n++;
      if (exp_q.size() == 0 || {bus.out_ch, bus.out_data, bus.out_ts} !== exp_q[0]) begin
        bad++;
        $display("FAIL enable_event: got %h want %h", {bus.out_ch, bus.out_data, bus.out_ts},
                 exp_q.size() ? exp_q[0] : 56'h0);
      end
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
    end
    total++;
    if (n !== 2) begin
      bad++;
      $display("FAIL enable_count: got %0d events want 2", n);
    end
    tick();
  endtask

  task automatic test_random();
    int n;
    int want;
    for (int i = 0; i < 300; i++) begin
      set_thr($urandom_range(0, 300), $urandom_range(0, 4), $urandom_range(0, 9) != 0);
      send($urandom_range(0, 7), int'($urandom_range(0, 600)) - 300);
      idle($urandom_range(0, 2));
    end
    idle(4);
    @(negedge user_clk);
    total++;
    if (drop_count !== 16'(DROP_EN ? drops : 0)) begin
      bad++;
      $display("FAIL random_drops: drop=%0d want %0d", drop_count, DROP_EN ? drops : 0);
    end
    tick();
    want = exp_q.size();
    n = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge user_clk);
      if (!bus.out_valid) break;
      total++;
      n++;
      if (exp_q.size() == 0 || {bus.out_ch, bus.out_data, bus.out_ts} !== exp_q[0]) begin
        bad++;
        $display("FAIL random_event: got %h want %h", {bus.out_ch, bus.out_data, bus.out_ts},
                 exp_q.size() ? exp_q[0] : 56'h0);
      end
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
    end
    total++;
    if (n !== want) begin
      bad++;
      $display("FAIL random_count: got %0d events want %0d", n, want);
    end
    tick();
  endtask

  task automatic test_mid_reset();
    int n;
    set_thr(100, 0, 1'b1);
    send(1, -200);
    send(2, -200);
    assert_rst();
    release_rst();
    idle(260);
    @(negedge user_clk);
    total++;
    if (bus.out_valid !== 1'b0 || drop_count !== 16'd0 || init_done !== 1'b1) begin
      bad++;
      $display("FAIL midreset_flush: v=%b drop=%0d init=%b want v=0 drop=0 init=1",
               bus.out_valid, drop_count, init_done);
    end
    tick();
    send(6, -300);
    idle(4);
    n = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge user_clk);
      if (!bus.out_valid) break;
      total++;
      n++;
      if (exp_q.size() == 0 || {bus.out_ch, bus.out_data, bus.out_ts} !== exp_q[0]) begin
        bad++;
        $display("FAIL midreset_event: got %h want %h", {bus.out_ch, bus.out_data, bus.out_ts},
                 exp_q.size() ? exp_q[0] : 56'h0);
      end
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
    end
    total++;
    if (n !== 1) begin
      bad++;
      $display("FAIL midreset_count: got %0d events want 1", n);
    end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_ch = '0;
    bus.in_data = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_single();
    test_deadtime(7, 2);
    test_deadtime(8, 0);
    test_fifo_full();
    test_enable();
    test_random();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
